// File: rtl/gpmc_async_bridge.sv
// rtl/gpmc_async_bridge.sv - GPMC asynchronous non-muxed device bridge to a single-outstanding local bus
//
// Oversamples the GPMC strobes in the clk domain. Each GPMC read or write
// becomes one local-bus request. wait_o stalls the host while the request
// is open. data_oe enables the pad drivers during a read data phase.
//
// Ports:
//   clk, rst            fabric clock; asynchronous active-high reset
//   cs_n, oe_n_re_n,    GPMC strobes, active low, asynchronous to clk
//   we_n
//   be0_n_cle, be1_n    GPMC byte enables, active low
//   addr, data_i        GPMC address and write data from the pads
//   data_o, data_oe     read data and output enable to the pads
//   wait_o              GPMC wait, high = stall
//   lb_req, lb_we,      local-bus request; held until lb_ack
//   lb_addr, lb_wdata,
//   lb_be
//   lb_ack, lb_rdata    local-bus completion pulse and read data
//   err                 single-cycle error pulse
//
// Optional feature macro: GPMC_TIMEOUT_EN. When it is defined, a local
// request left without lb_ack for TIMEOUT_CYCLES is completed by the bridge.
// In that case a read returns 16'hDEAD.

module gpmc_async_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  oe_n_re_n,
  input  logic                  we_n,
  input  logic                  be0_n_cle,
  input  logic                  be1_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_oe,
  output logic                  wait_o,
  output logic                  lb_req,
  output logic                  lb_we,
  output logic [ADDR_WIDTH-1:0] lb_addr,
  output logic [DATA_WIDTH-1:0] lb_wdata,
  output logic [1:0]            lb_be,
  input  logic                  lb_ack,
  input  logic [DATA_WIDTH-1:0] lb_rdata,
  output logic                  err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_END, RD_REQ, RD_HOLD} state_t;

  state_t state, state_nx;

  // Strobe synchronisers. The *_d flops hold the previous synced value for
  // edge detection. Everything resets to the inactive (high) level.
  logic [1:0] cs_sync, oe_sync, we_sync;
  logic       oe_d, we_d;
  logic       cs_s, oe_s, we_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync <= 2'b11;
      oe_sync <= 2'b11;
      we_sync <= 2'b11;
      oe_d    <= 1'b1;
      we_d    <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[0], cs_n};
      oe_sync <= {oe_sync[0], oe_n_re_n};
      we_sync <= {we_sync[0], we_n};
      oe_d    <= oe_s;
      we_d    <= we_s;
    end
  end

  assign cs_s = cs_sync[1];
  assign oe_s = oe_sync[1];
  assign we_s = we_sync[1];

  logic we_fall, oe_fall, start_wr, start_rd;
  logic in_req, aborted, abort_now, done, timed_out;
  logic [DATA_WIDTH-1:0] rd_result;

  assign we_fall  = we_d & ~we_s;
  assign oe_fall  = oe_d & ~oe_s;
  assign start_wr = (state == IDLE) & ~cs_s & we_fall;
  assign start_rd = (state == IDLE) & ~cs_s & oe_fall & ~we_fall;
  assign in_req   = (state == WR_REQ) | (state == RD_REQ);
  assign done     = in_req & (lb_ack | timed_out);

  // If the host drops cs_n while a request is open, the request still runs
  // to completion on the local side, but its result never reaches the pads.
  assign abort_now = aborted | cs_s;

`ifdef GPMC_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  logic [CNT_W-1:0] to_cnt;

  // The count is 0 in the first request cycle. The bridge completes the
  // request itself on the TIMEOUT_CYCLES-th cycle without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          to_cnt <= '0;
    else if (!in_req) to_cnt <= '0;
    else              to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = in_req & ~lb_ack & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rd_result = timed_out ? DATA_WIDTH'(TIMEOUT_DATA) : lb_rdata;
`else
  assign timed_out = 1'b0;
  assign rd_result = lb_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_nx = WR_REQ;
        else if (start_rd) state_nx = RD_REQ;
      end
      WR_REQ:  if (done) state_nx = abort_now ? IDLE : WR_END;
      WR_END:  if (we_s || cs_s) state_nx = IDLE;
      RD_REQ:  if (done) state_nx = abort_now ? IDLE : RD_HOLD;
      RD_HOLD: if (oe_s || cs_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The request strobes are decoded from the state. They drop on the same
  // edge that consumes lb_ack, and they clear asynchronously with rst.
  assign lb_req = in_req;
  assign lb_we  = (state == WR_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted  <= 1'b0;
      lb_addr  <= '0;
      lb_wdata <= '0;
      lb_be    <= 2'b00;
      data_o   <= '0;
      data_oe  <= 1'b0;
      wait_o   <= 1'b0;
      err      <= 1'b0;
    end else begin
      aborted <= in_req & abort_now;
      // Error sources: both strobes falling together, an ack with no
      // request open, an aborted request completing, or a timeout.
      err <= (start_wr & oe_fall) | (lb_ack & ~in_req) | (done & abort_now) | timed_out;

      if (start_wr || start_rd) begin
        lb_addr  <= addr;
        lb_wdata <= data_i;
        lb_be    <= ~{be1_n, be0_n_cle};
        wait_o   <= 1'b1;
      end

      if (done) begin
        if (state == RD_REQ && !abort_now) begin
          // Keep wait high for one more cycle so that data is on the pads
          // before the host samples the wait release.
          data_o  <= rd_result;
          data_oe <= 1'b1;
        end else begin
          wait_o  <= 1'b0;
        end
      end

      if (state == RD_HOLD) begin
        wait_o <= 1'b0;
        if (oe_s || cs_s) data_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpmc_async_bridge.sv
// tb/tb_gpmc_async_bridge.sv - self-checking bench for gpmc_async_bridge

module tb_gpmc_async_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, oe_n_re_n, we_n, be0_n_cle, be1_n;
  logic [15:0] addr, data_i, data_o, lb_addr, lb_wdata, lb_rdata;
  logic        data_oe, wait_o, lb_req, lb_we, lb_ack, err;
  logic [1:0]  lb_be;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gpmc_async_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .oe_n_re_n(oe_n_re_n), .we_n(we_n),
    .be0_n_cle(be0_n_cle), .be1_n(be1_n), .addr(addr), .data_i(data_i),
    .data_o(data_o), .data_oe(data_oe), .wait_o(wait_o), .lb_req(lb_req),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_be(lb_be),
    .lb_ack(lb_ack), .lb_rdata(lb_rdata), .err(err)
  );

  always @(negedge clk) if (err) err_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!lb_req && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One complete GPMC access, with the bench acting as the local target.
  task automatic txn(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                     input bit b1, input bit b0, input logic [15:0] rd, input int dly,
                     input logic [1:0] exp_be, input logic [15:0] exp_rd);
    int n;
    int e0;
    e0 = err_cnt;
    @(negedge clk);
    cs_n = 1'b0; addr = a; data_i = wd; be1_n = b1; be0_n_cle = b0;
    @(negedge clk);
    if (wr) we_n = 1'b0; else oe_n_re_n = 1'b0;
    wait_req(n);
    chk("req_latency", n, 3);
    chk("lb_we", lb_we, wr);
    chk("lb_addr", lb_addr, a);
    if (wr) chk("lb_wdata", lb_wdata, wd);
    chk("lb_be", lb_be, exp_be);
    chk("wait_during_req", wait_o, 1);
    repeat (dly) @(negedge clk);
    lb_ack = 1'b1; lb_rdata = rd;
    @(negedge clk);
    lb_ack = 1'b0; lb_rdata = 16'($urandom);
    chk("req_dropped", lb_req, 0);
    if (wr) begin
      chk("wr_wait_release", wait_o, 0);
      chk("wr_no_oe", data_oe, 0);
    end else begin
      chk("rd_oe_before_wait", {data_oe, wait_o}, 2'b11);
      chk("rd_data", data_o, exp_rd);
      @(negedge clk);
      chk("rd_wait_release", wait_o, 0);
    end
    we_n = 1'b1; oe_n_re_n = 1'b1;
    n = 0;
    while (data_oe && n < 10) begin @(negedge clk); n++; end
    if (!wr) chk("oe_release_latency", n, 3);
    settle();
    chk("txn_err_count", err_cnt - e0, 0);
    chk("idle_wait_low", wait_o, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] wd;
    bit          b1;
    bit          b0;
    logic [15:0] rd;
    int          dly;
    logic [1:0]  exp_be;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] mem [8];

  initial begin
    int n;
    int e0;
    bit oe_seen;

    rst = 1'b1; cs_n = 1'b1; oe_n_re_n = 1'b1; we_n = 1'b1;
    be0_n_cle = 1'b1; be1_n = 1'b1; addr = '0; data_i = '0;
    lb_ack = 1'b0; lb_rdata = '0;

    vecs[0] = '{1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 5, 2'b11, 16'h0000};
    vecs[1] = '{0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 3, 2'b11, 16'hBEEF};
    vecs[2] = '{1, 16'h0042, 16'h00A5, 1, 0, 16'h0000, 2, 2'b01, 16'h0000};
    vecs[3] = '{1, 16'h0044, 16'h5A00, 0, 1, 16'h0000, 1, 2'b10, 16'h0000};
    vecs[4] = '{0, 16'hFFFE, 16'h0000, 1, 1, 16'h8001, 0, 2'b00, 16'h8001};
    vecs[5] = '{1, 16'h8000, 16'hFFFF, 1, 1, 16'h0000, 0, 2'b00, 16'h0000};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_o, data_oe, wait_o, lb_req, lb_we, err}, '0);
    chk("reset_lb_fields", {lb_addr, lb_wdata, lb_be}, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i])
      txn(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].b1, vecs[i].b0,
          vecs[i].rd, vecs[i].dly, vecs[i].exp_be, vecs[i].exp_rd);

    // Random traffic against a small register-file model.
    for (int i = 0; i < 8; i++) mem[i] = 16'hA5A5 ^ 16'(i * 16'h1111);
    for (int k = 0; k < 24; k++) begin
      bit          wr;
      bit          b1, b0;
      int          idx;
      logic [15:0] wd;
      logic [15:0] mask;
      wr  = 1'($urandom);
      b1  = 1'($urandom);
      b0  = 1'($urandom);
      idx = int'($urandom_range(0, 7));
      wd  = 16'($urandom);
      if (wr) begin
        mask = {b1 ? 8'h00 : 8'hFF, b0 ? 8'h00 : 8'hFF};
        txn(1, 16'h0100 + 16'(idx), wd, b1, b0, 16'h0000, int'($urandom_range(0, 6)),
            {~b1, ~b0}, 16'h0000);
        mem[idx] = (mem[idx] & ~mask) | (wd & mask);
      end else begin
        txn(0, 16'h0100 + 16'(idx), wd, b1, b0, mem[idx], int'($urandom_range(0, 6)),
            {~b1, ~b0}, mem[idx]);
      end
    end

    // we_n and oe_n fall together: the write wins and err pulses once.
    e0 = err_cnt;
    @(negedge clk);
    cs_n = 1'b0; addr = 16'h0022; data_i = 16'h5A5A; be1_n = 1'b0; be0_n_cle = 1'b0;
    @(negedge clk);
    we_n = 1'b0; oe_n_re_n = 1'b0;
    wait_req(n);
    chk("both_req_latency", n, 3);
    chk("both_is_write", lb_we, 1);
    chk("both_wdata", lb_wdata, 16'h5A5A);
    lb_ack = 1'b1;
    @(negedge clk);
    lb_ack = 1'b0;
    chk("both_wait_release", wait_o, 0);
    we_n = 1'b1; oe_n_re_n = 1'b1;
    settle();
    chk("both_err_once", err_cnt - e0, 1);

    // cs_n rises during a read request. The ack arrives later.
    e0 = err_cnt;
    oe_seen = 1'b0;
    @(negedge clk);
    cs_n = 1'b0; addr = 16'h0030;
    @(negedge clk);
    oe_n_re_n = 1'b0;
    wait_req(n);
    chk("abort_req_latency", n, 3);
    cs_n = 1'b1;
    repeat (5) begin @(negedge clk); oe_seen |= data_oe; end
    chk("abort_req_held", lb_req, 1);
    lb_ack = 1'b1; lb_rdata = 16'h7777;
    @(negedge clk);
    lb_ack = 1'b0;
    repeat (4) begin oe_seen |= data_oe; @(negedge clk); end
    chk("abort_no_oe", oe_seen, 0);
    chk("abort_req_dropped", lb_req, 0);
    chk("abort_wait_low", wait_o, 0);
    chk("abort_err_once", err_cnt - e0, 1);
    oe_n_re_n = 1'b1;
    repeat (4) @(negedge clk);
    txn(0, 16'h0031, 16'h0000, 0, 0, 16'h1357, 1, 2'b11, 16'h1357);

    // An ack while idle is ignored and flagged.
    e0 = err_cnt;
    lb_ack = 1'b1;
    @(negedge clk);
    lb_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ack_err", err_cnt - e0, 1);
    chk("idle_ack_no_req", lb_req, 0);

    // A read that never receives an ack.
    @(negedge clk);
    cs_n = 1'b0; addr = 16'h0044;
    @(negedge clk);
    oe_n_re_n = 1'b0;
    wait_req(n);
    e0 = err_cnt;
`ifdef GPMC_TIMEOUT_EN
    n = 0;
    while (wait_o && n < 400) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 256);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_data", data_o, 16'hDEAD);
    chk("timeout_oe", data_oe, 1);
    chk("timeout_req_dropped", lb_req, 0);
`else
    repeat (300) @(negedge clk);
    chk("noack_wait_high", wait_o, 1);
    chk("noack_req_held", lb_req, 1);
    chk("noack_no_err", err_cnt - e0, 0);
    lb_ack = 1'b1; lb_rdata = 16'h2468;
    @(negedge clk);
    lb_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_data", data_o, 16'h2468);
    chk("late_ack_wait", wait_o, 0);
`endif
    oe_n_re_n = 1'b1;
    settle();

    // Reset while a request is open.
    @(negedge clk);
    cs_n = 1'b0; addr = 16'h0050;
    @(negedge clk);
    oe_n_re_n = 1'b0;
    wait_req(n);
    chk("pre_reset_req", {lb_req, wait_o}, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_reset_drop", {lb_req, wait_o, data_oe}, 3'b000);
    cs_n = 1'b1; oe_n_re_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    txn(1, 16'h0060, 16'hC0DE, 0, 0, 16'h0000, 2, 2'b11, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpmc_async_bridge.md
Name: gpmc_async_bridge

Overview:
- Device-side bridge from the processor's GPMC (non-multiplexed, asynchronous mode) to a simple single-outstanding local register bus.
- All GPMC control strobes are oversampled in the fabric clock domain.
- Sequences each GPMC read/write into one local-bus request, drives GPMC wait while the local bus is busy, and controls the data-bus output enable.
- Sits between the top-level GPMC pads (tristate split at top) and the register file / local interconnect.

Parameters:
ADDR_WIDTH, 16, GPMC/local address width
DATA_WIDTH, 16, GPMC/local data width
TIMEOUT_CYCLES, 255, local-bus ack timeout in clk cycles (used only with GPMC_TIMEOUT_EN)

Ports:
clk  input  1  fabric clock, at least 4x GPMC strobe rate
rst  input  1  asynchronous, active-high reset
cs_n  input  1  GPMC chip select for this device, active low
oe_n_re_n  input  1  GPMC output enable, active low
we_n  input  1  GPMC write enable, active low
be0_n_cle  input  1  byte enable, low byte, active low
be1_n  input  1  byte enable, high byte, active low
addr  input  ADDR_WIDTH  GPMC address
data_i  input  DATA_WIDTH  GPMC data from pad
data_o  output  DATA_WIDTH  GPMC read data to pad
data_oe  output  1  pad output enable
wait_o  output  1  GPMC wait, active high = stall
lb_req  output  1  local request, held until lb_ack
lb_we  output  1  local write (1) / read (0)
lb_addr  output  ADDR_WIDTH  local address
lb_wdata  output  DATA_WIDTH  local write data
lb_be  output  2  local byte enables, active high
lb_ack  input  1  local completion, single-cycle pulse
lb_rdata  input  DATA_WIDTH  local read data, valid with lb_ack
err  output  1  single-cycle error pulse

Behaviour:
- Interface clocking/reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0; data_o = 0; FSM = IDLE.
- Synchronisers: cs_n, oe_n_re_n and we_n each pass through 2-FF synchronisers (reset to 1).
- Capture: addr, data_i and byte enables are captured in the cycle a synced strobe is first seen low. GPMC timing guarantees they are stable by then.
- Start condition: synced cs_n=0 and a falling edge on synced we_n or oe_n. Write wins if both fall in the same cycle; err pulses in that case.
- FSM states:
  - IDLE: wait for a start condition.
    - Write start -> WR_REQ: capture lb_addr, lb_wdata, lb_be = ~{be1_n, be0_n}.
    - Read start -> RD_REQ.
    - In the same cycle, wait_o=1 and lb_req=1.
  - WR_REQ: lb_req=1, lb_we=1. On lb_ack -> lb_req=0, wait_o=0 -> WR_END.
  - WR_END: when synced we_n=1 or cs_n=1 -> IDLE.
  - RD_REQ: lb_req=1, lb_we=0. On lb_ack:
    - data_o <= lb_rdata, data_oe=1 in the next cycle.
    - wait_o=0 one cycle after data_oe rises, so data is valid before wait release.
    - -> RD_HOLD.
  - RD_HOLD: data_oe=1. When synced oe_n=1 or cs_n=1 -> data_oe=0 -> IDLE.
- Latency: strobe pin edge to lb_req high = 3 clk (2 sync + 1 register). lb_ack to wait_o low = 1 clk (write) or 2 clk (read).
- cs_n deasserting mid-request: the local request still completes; the result is discarded; data_oe is never raised; err pulses.
- lb_ack while idle: ignored; err pulses.
- Throughput: only one transaction outstanding. No new start is accepted until IDLE.
- wait_o is never high in IDLE.
- Reset mid-transaction: lb_req, wait_o and data_oe drop asynchronously. The local side must tolerate the abandoned request.

Optional Feature:
Macro: GPMC_TIMEOUT_EN
- Defined:
  - 8-bit-or-wider counter runs in WR_REQ/RD_REQ.
  - If TIMEOUT_CYCLES elapse without lb_ack: drop lb_req, pulse err, release wait_o.
  - A read returns the constant 16'hDEAD (truncated/zero-extended to DATA_WIDTH).
  - FSM proceeds to WR_END/RD_HOLD as for a normal ack.
- Undefined: no counter; the FSM waits for lb_ack indefinitely.

Test Plan:
- Write 0x1234 to addr 0x0040, both BEs low, lb_ack 5 cycles after lb_req -> lb_we=1, lb_addr=0x0040, lb_wdata=0x1234, lb_be=2'b11; wait_o falls 1 clk after ack; back in IDLE after we_n rises.
- Read addr 0x0010, lb_rdata=0xBEEF ack after 3 cycles -> data_o=0xBEEF, data_oe=1 before wait_o falls; data_oe=0 within 3 clk of oe_n rising.
- Byte write with be1_n=1, be0_n=0 -> lb_be=2'b01.
- we_n and oe_n fall simultaneously -> write performed, err pulses once.
- cs_n rises during RD_REQ, ack arrives later -> data_oe never asserts, err pulses, FSM in IDLE.
- With GPMC_TIMEOUT_EN, read with no lb_ack -> after 255 cycles err pulses, data_o=0xDEAD, wait_o=0. Without the macro -> wait_o stays high.
